// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register slice.
// Holds default widths, the stage FSM encoding and the bubble control constant.
package id_ex_stage_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ALU_OP_W   = 6;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned CNT_W      = 16;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  // Control bits that must be cleared for an EX slot to be a harmless bubble
  typedef struct packed {
    logic valid;
    logic reg_wr_en;
    logic mem_rd;
    logic mem_wr;
  } bubble_ctrl_t;

  localparam bubble_ctrl_t BUBBLE_CTRL = '{valid: 1'b0, reg_wr_en: 1'b0, mem_rd: 1'b0, mem_wr: 1'b0};

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator (purely combinational).
// Ports:
//   ex_valid, ex_mem_rd, ex_rt        : instruction currently in EX
//   id_valid, id_uses_rs, id_uses_rt,
//   id_rs, id_rt                      : instruction currently in ID
//   hazard_c                          : ID reads the register the EX load is writing
module load_use_detect
  import id_ex_stage_pkg::*;
(
  input  logic                  ex_valid,
  input  logic                  ex_mem_rd,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  id_valid,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  output logic                  hazard_c
);

  logic ex_is_load_c;
  logic rs_match_c;
  logic rt_match_c;

  // r0 is hardwired zero, so a load into it never produces a dependency
  assign ex_is_load_c = ex_valid & ex_mem_rd & (ex_rt != '0);
  assign rs_match_c   = id_uses_rs & (id_rs == ex_rt);
  assign rt_match_c   = id_uses_rt & (id_rt == ex_rt);
  assign hazard_c     = ex_is_load_c & id_valid & (rs_match_c | rt_match_c);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection, flush, debug halt
// and a saturating stall-cycle counter.
// Ports:
//   i_clk, i_rst_n          : clock, async active-low reset
//   i_*_ID, i_* data/ctrl   : decoded instruction fields from ID
//   i_flush, i_halt         : taken branch/jump kill, debug freeze
//   i_cnt_clr               : clear stall counter
//   o_*_EX                  : registered copies of the ID fields
//   o_stall                 : combinational stall request to PC and IF/ID
//   o_stall_count           : saturating count of load-use stall cycles
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned DATA_W   = id_ex_stage_pkg::DATA_W,
  parameter int unsigned ALU_OP_W = id_ex_stage_pkg::ALU_OP_W,
  parameter int unsigned CNT_W    = id_ex_stage_pkg::CNT_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid_ID,
  input  logic [REG_ADDR_W-1:0] i_rs_ID,
  input  logic [REG_ADDR_W-1:0] i_rt_ID,
  input  logic [REG_ADDR_W-1:0] i_rd_ID,
  input  logic                  i_uses_rs_ID,
  input  logic                  i_uses_rt_ID,
  input  logic [DATA_W-1:0]     i_rs_data,
  input  logic [DATA_W-1:0]     i_rt_data,
  input  logic [DATA_W-1:0]     i_imm,
  input  logic [4:0]            i_shamt,
  input  logic [ALU_OP_W-1:0]   i_ALU_op,
  input  logic [1:0]            i_flg_ALU_src_A,
  input  logic                  i_flg_ALU_src_B,
  input  logic                  i_flg_reg_wr_en,
  input  logic                  i_flg_mem_rd,
  input  logic                  i_flg_mem_wr,
  input  logic                  i_flg_WB_src,
  input  logic [1:0]            i_flg_reg_dst,
  input  logic                  i_flush,
  input  logic                  i_halt,
  input  logic                  i_cnt_clr,
  output logic                  o_valid_EX,
  output logic [REG_ADDR_W-1:0] o_rs_EX,
  output logic [REG_ADDR_W-1:0] o_rt_EX,
  output logic [REG_ADDR_W-1:0] o_rd_EX,
  output logic                  o_uses_rs_EX,
  output logic                  o_uses_rt_EX,
  output logic [DATA_W-1:0]     o_rs_data_EX,
  output logic [DATA_W-1:0]     o_rt_data_EX,
  output logic [DATA_W-1:0]     o_imm_EX,
  output logic [4:0]            o_shamt_EX,
  output logic [ALU_OP_W-1:0]   o_ALU_op_EX,
  output logic [1:0]            o_flg_ALU_src_A_EX,
  output logic                  o_flg_ALU_src_B_EX,
  output logic                  o_flg_reg_wr_en_EX,
  output logic                  o_flg_mem_rd_EX,
  output logic                  o_flg_mem_wr_EX,
  output logic                  o_flg_WB_src_EX,
  output logic [1:0]            o_flg_reg_dst_EX,
  output logic                  o_stall,
  output logic [CNT_W-1:0]      o_stall_count
);

  state_e state_q;
  state_e state_d;
  logic   hazard_c;
  logic   ex_load_c;
  logic   ex_bubble_c;
  logic   cnt_en_c;

  load_use_detect u_load_use_detect (
    .ex_valid   (o_valid_EX),
    .ex_mem_rd  (o_flg_mem_rd_EX),
    .ex_rt      (o_rt_EX),
    .id_valid   (i_valid_ID),
    .id_uses_rs (i_uses_rs_ID),
    .id_uses_rt (i_uses_rt_ID),
    .id_rs      (i_rs_ID),
    .id_rt      (i_rt_ID),
    .hazard_c   (hazard_c)
  );

  // A flush kills the ID instruction anyway, and a halt freezes everything
  assign o_stall = hazard_c & ~i_flush & ~i_halt;

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: halt dominates, otherwise follow the stall request
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_HALT: begin
        if (!i_halt) begin
          state_d = o_stall ? ST_STALL : ST_RUN;
        end
      end
      default: begin
        if (i_halt) begin
          state_d = ST_HALT;
        end else if (o_stall) begin
          state_d = ST_STALL;
        end else begin
          state_d = ST_RUN;
        end
      end
    endcase
  end

  // FSM outputs: per-edge action, priority halt > flush > stall > advance
  always_comb begin
    ex_load_c   = 1'b0;
    ex_bubble_c = 1'b0;
    cnt_en_c    = 1'b0;
    if (!i_halt) begin
      ex_load_c   = 1'b1;
      ex_bubble_c = i_flush | o_stall | ~i_valid_ID;
      cnt_en_c    = 1'b1;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      {o_valid_EX, o_flg_reg_wr_en_EX, o_flg_mem_rd_EX, o_flg_mem_wr_EX} <= BUBBLE_CTRL;
      o_rs_EX            <= '0;
      o_rt_EX            <= '0;
      o_rd_EX            <= '0;
      o_uses_rs_EX       <= 1'b0;
      o_uses_rt_EX       <= 1'b0;
      o_rs_data_EX       <= '0;
      o_rt_data_EX       <= '0;
      o_imm_EX           <= '0;
      o_shamt_EX         <= '0;
      o_ALU_op_EX        <= '0;
      o_flg_ALU_src_A_EX <= '0;
      o_flg_ALU_src_B_EX <= 1'b0;
      o_flg_WB_src_EX    <= 1'b0;
      o_flg_reg_dst_EX   <= '0;
    end else if (ex_load_c) begin
      if (ex_bubble_c) begin
        {o_valid_EX, o_flg_reg_wr_en_EX, o_flg_mem_rd_EX, o_flg_mem_wr_EX} <= BUBBLE_CTRL;
        o_rs_EX            <= '0;
        o_rt_EX            <= '0;
        o_rd_EX            <= '0;
        o_uses_rs_EX       <= 1'b0;
        o_uses_rt_EX       <= 1'b0;
        o_rs_data_EX       <= '0;
        o_rt_data_EX       <= '0;
        o_imm_EX           <= '0;
        o_shamt_EX         <= '0;
        o_ALU_op_EX        <= '0;
        o_flg_ALU_src_A_EX <= '0;
        o_flg_ALU_src_B_EX <= 1'b0;
        o_flg_WB_src_EX    <= 1'b0;
        o_flg_reg_dst_EX   <= '0;
      end else begin
        o_valid_EX         <= i_valid_ID;
        o_flg_reg_wr_en_EX <= i_flg_reg_wr_en;
        o_flg_mem_rd_EX    <= i_flg_mem_rd;
        o_flg_mem_wr_EX    <= i_flg_mem_wr;
        o_rs_EX            <= i_rs_ID;
        o_rt_EX            <= i_rt_ID;
        o_rd_EX            <= i_rd_ID;
        o_uses_rs_EX       <= i_uses_rs_ID;
        o_uses_rt_EX       <= i_uses_rt_ID;
        o_rs_data_EX       <= i_rs_data;
        o_rt_data_EX       <= i_rt_data;
        o_imm_EX           <= i_imm;
        o_shamt_EX         <= i_shamt;
        o_ALU_op_EX        <= i_ALU_op;
        o_flg_ALU_src_A_EX <= i_flg_ALU_src_A;
        o_flg_ALU_src_B_EX <= i_flg_ALU_src_B;
        o_flg_WB_src_EX    <= i_flg_WB_src;
        o_flg_reg_dst_EX   <= i_flg_reg_dst;
      end
    end
  end

  // Saturating stall counter; clear beats increment, halt freezes it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stall_count <= '0;
    end else if (cnt_en_c) begin
      if (i_cnt_clr) begin
        o_stall_count <= '0;
      end else if (o_stall && (o_stall_count != '1)) begin
        o_stall_count <= o_stall_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        valid_id;
  logic [4:0]  rs_id, rt_id, rd_id;
  logic        uses_rs_id, uses_rt_id;
  logic [31:0] rs_data, rt_data, imm;
  logic [4:0]  shamt;
  logic [5:0]  alu_op;
  logic [1:0]  src_a;
  logic        src_b;
  logic        reg_wr_en, mem_rd, mem_wr, wb_src;
  logic [1:0]  reg_dst;
  logic        flush, halt, cnt_clr;

  logic        valid_ex;
  logic [4:0]  rs_ex, rt_ex, rd_ex;
  logic        uses_rs_ex, uses_rt_ex;
  logic [31:0] rs_data_ex, rt_data_ex, imm_ex;
  logic [4:0]  shamt_ex;
  logic [5:0]  alu_op_ex;
  logic [1:0]  src_a_ex;
  logic        src_b_ex;
  logic        reg_wr_en_ex, mem_rd_ex, mem_wr_ex, wb_src_ex;
  logic [1:0]  reg_dst_ex;
  logic        stall;
  logic [15:0] stall_count;

  // Narrow-counter instance used to reach saturation within a short run
  logic        s_valid, s_urs, s_urt, s_srcb, s_rwe, s_mrd, s_mwr, s_wb, s_stall;
  logic [4:0]  s_rs, s_rt, s_rd, s_shamt;
  logic [31:0] s_rsd, s_rtd, s_imm;
  logic [5:0]  s_op;
  logic [1:0]  s_srca, s_rdst;
  logic [3:0]  s_cnt;

  int n_checks = 0;
  int n_errors = 0;

  id_ex_stage dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid_ID(valid_id),
    .i_rs_ID(rs_id), .i_rt_ID(rt_id), .i_rd_ID(rd_id),
    .i_uses_rs_ID(uses_rs_id), .i_uses_rt_ID(uses_rt_id),
    .i_rs_data(rs_data), .i_rt_data(rt_data), .i_imm(imm),
    .i_shamt(shamt), .i_ALU_op(alu_op), .i_flg_ALU_src_A(src_a), .i_flg_ALU_src_B(src_b),
    .i_flg_reg_wr_en(reg_wr_en), .i_flg_mem_rd(mem_rd), .i_flg_mem_wr(mem_wr),
    .i_flg_WB_src(wb_src), .i_flg_reg_dst(reg_dst),
    .i_flush(flush), .i_halt(halt), .i_cnt_clr(cnt_clr),
    .o_valid_EX(valid_ex), .o_rs_EX(rs_ex), .o_rt_EX(rt_ex), .o_rd_EX(rd_ex),
    .o_uses_rs_EX(uses_rs_ex), .o_uses_rt_EX(uses_rt_ex),
    .o_rs_data_EX(rs_data_ex), .o_rt_data_EX(rt_data_ex), .o_imm_EX(imm_ex),
    .o_shamt_EX(shamt_ex), .o_ALU_op_EX(alu_op_ex),
    .o_flg_ALU_src_A_EX(src_a_ex), .o_flg_ALU_src_B_EX(src_b_ex),
    .o_flg_reg_wr_en_EX(reg_wr_en_ex), .o_flg_mem_rd_EX(mem_rd_ex),
    .o_flg_mem_wr_EX(mem_wr_ex), .o_flg_WB_src_EX(wb_src_ex),
    .o_flg_reg_dst_EX(reg_dst_ex), .o_stall(stall), .o_stall_count(stall_count)
  );

  id_ex_stage #(.CNT_W(4)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid_ID(valid_id),
    .i_rs_ID(rs_id), .i_rt_ID(rt_id), .i_rd_ID(rd_id),
    .i_uses_rs_ID(uses_rs_id), .i_uses_rt_ID(uses_rt_id),
    .i_rs_data(rs_data), .i_rt_data(rt_data), .i_imm(imm),
    .i_shamt(shamt), .i_ALU_op(alu_op), .i_flg_ALU_src_A(src_a), .i_flg_ALU_src_B(src_b),
    .i_flg_reg_wr_en(reg_wr_en), .i_flg_mem_rd(mem_rd), .i_flg_mem_wr(mem_wr),
    .i_flg_WB_src(wb_src), .i_flg_reg_dst(reg_dst),
    .i_flush(flush), .i_halt(halt), .i_cnt_clr(cnt_clr),
    .o_valid_EX(s_valid), .o_rs_EX(s_rs), .o_rt_EX(s_rt), .o_rd_EX(s_rd),
    .o_uses_rs_EX(s_urs), .o_uses_rt_EX(s_urt),
    .o_rs_data_EX(s_rsd), .o_rt_data_EX(s_rtd), .o_imm_EX(s_imm),
    .o_shamt_EX(s_shamt), .o_ALU_op_EX(s_op),
    .o_flg_ALU_src_A_EX(s_srca), .o_flg_ALU_src_B_EX(s_srcb),
    .o_flg_reg_wr_en_EX(s_rwe), .o_flg_mem_rd_EX(s_mrd),
    .o_flg_mem_wr_EX(s_mwr), .o_flg_WB_src_EX(s_wb),
    .o_flg_reg_dst_EX(s_rdst), .o_stall(s_stall), .o_stall_count(s_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        valid;
    logic [4:0]  rs, rt;
    logic        urs, urt, md;
    logic [31:0] imm;
    logic        fl, clr;
    logic        e_stall;
    logic        e_valid;
    logic [4:0]  e_rt;
    logic        e_md;
    logic [31:0] e_imm;
    logic [15:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                              input logic urs, input logic urt, input logic md,
                              input logic [31:0] im, input logic fl, input logic clr,
                              input logic es, input logic ev, input logic [4:0] ert,
                              input logic emd, input logic [31:0] eim, input logic [15:0] ec);
    vec_t r;
    r.valid = v; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt; r.md = md;
    r.imm = im; r.fl = fl; r.clr = clr; r.e_stall = es; r.e_valid = ev;
    r.e_rt = ert; r.e_md = emd; r.e_imm = eim; r.e_cnt = ec;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic md,
                          input logic [31:0] im);
    valid_id = v; rs_id = rs; rt_id = rt; rd_id = 5'd0;
    uses_rs_id = urs; uses_rt_id = urt;
    rs_data = 32'h0; rt_data = 32'h0; imm = im;
    shamt = 5'd0; alu_op = 6'd0; src_a = 2'd0; src_b = 1'b0;
    reg_wr_en = 1'b0; mem_rd = md; mem_wr = 1'b0; wb_src = 1'b0; reg_dst = 2'd0;
  endtask

  // One load followed by one dependent ALU op (one stall cycle)
  task automatic hazard_pair(input logic clr, input string tag, input logic [15:0] exp_cnt,
                             input logic [3:0] exp_sat);
    @(negedge clk);
    drive_id(1'b1, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 32'h55); cnt_clr = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    drive_id(1'b1, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 32'h66); cnt_clr = clr;
    #1 chk({tag, " stall"}, 64'(stall), 64'(1'b1));
    @(posedge clk); #1;
    chk({tag, " cnt"}, 64'(stall_count), 64'(exp_cnt));
    chk({tag, " satcnt"}, 64'(s_cnt), 64'(exp_sat));
    cnt_clr = 1'b0;
  endtask

  vec_t vecs[15];

  initial begin
    vecs[0]  = mk(1, 1, 5,  1, 0, 1, 32'h100, 0, 0, 0, 1, 5,  1, 32'h100, 0);
    vecs[1]  = mk(1, 5, 6,  1, 1, 0, 32'h200, 0, 0, 1, 0, 0,  0, 32'h0,   1);
    vecs[2]  = mk(1, 5, 6,  1, 1, 0, 32'h200, 0, 0, 0, 1, 6,  0, 32'h200, 1);
    vecs[3]  = mk(1, 2, 0,  1, 0, 1, 32'h300, 0, 0, 0, 1, 0,  1, 32'h300, 1);
    vecs[4]  = mk(1, 0, 0,  1, 1, 0, 32'h400, 0, 0, 0, 1, 0,  0, 32'h400, 1);
    vecs[5]  = mk(1, 3, 7,  1, 0, 1, 32'h500, 0, 0, 0, 1, 7,  1, 32'h500, 1);
    vecs[6]  = mk(1, 1, 7,  1, 1, 0, 32'h600, 1, 0, 0, 0, 0,  0, 32'h0,   1);
    vecs[7]  = mk(1, 1, 7,  1, 0, 1, 32'h700, 0, 0, 0, 1, 7,  1, 32'h700, 1);
    vecs[8]  = mk(1, 8, 7,  1, 0, 0, 32'h800, 0, 0, 0, 1, 7,  0, 32'h800, 1);
    vecs[9]  = mk(0, 7, 7,  1, 1, 0, 32'h900, 0, 0, 0, 0, 0,  0, 32'h0,   1);
    vecs[10] = mk(1, 1, 9,  0, 0, 1, 32'hA00, 0, 0, 0, 1, 9,  1, 32'hA00, 1);
    vecs[11] = mk(0, 9, 9,  1, 1, 0, 32'hB00, 0, 0, 0, 0, 0,  0, 32'h0,   1);
    vecs[12] = mk(1, 1, 9,  0, 0, 1, 32'hC00, 0, 0, 0, 1, 9,  1, 32'hC00, 1);
    vecs[13] = mk(1, 9, 3,  1, 0, 0, 32'hD00, 0, 1, 1, 0, 0,  0, 32'h0,   0);
    vecs[14] = mk(1, 9, 10, 1, 0, 0, 32'hE00, 0, 0, 0, 1, 10, 0, 32'hE00, 0);

    // Reset with a live-looking ID instruction on the inputs
    rst_n = 1'b0; flush = 1'b0; halt = 1'b0; cnt_clr = 1'b0;
    drive_id(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 32'hDEAD);
    repeat (3) @(posedge clk);
    #1;
    chk("rst valid", 64'(valid_ex), 64'(1'b0));
    chk("rst imm", 64'(imm_ex), 64'(32'h0));
    chk("rst mem_rd", 64'(mem_rd_ex), 64'(1'b0));
    chk("rst stall", 64'(stall), 64'(1'b0));
    chk("rst cnt", 64'(stall_count), 64'(16'h0));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 15; i++) begin
      if (i != 0) @(negedge clk);
      drive_id(vecs[i].valid, vecs[i].rs, vecs[i].rt, vecs[i].urs, vecs[i].urt,
               vecs[i].md, vecs[i].imm);
      flush = vecs[i].fl; cnt_clr = vecs[i].clr; halt = 1'b0;
      #1 chk($sformatf("v%0d stall", i), 64'(stall), 64'(vecs[i].e_stall));
      @(posedge clk); #1;
      chk($sformatf("v%0d valid", i), 64'(valid_ex), 64'(vecs[i].e_valid));
      chk($sformatf("v%0d rt", i), 64'(rt_ex), 64'(vecs[i].e_rt));
      chk($sformatf("v%0d mem_rd", i), 64'(mem_rd_ex), 64'(vecs[i].e_md));
      chk($sformatf("v%0d imm", i), 64'(imm_ex), 64'(vecs[i].e_imm));
      chk($sformatf("v%0d cnt", i), 64'(stall_count), 64'(vecs[i].e_cnt));
    end
    flush = 1'b0; cnt_clr = 1'b0;

    // Halt: load lw rt=5, then freeze for 3 cycles with a hazarding ID
    @(negedge clk);
    drive_id(1'b1, 5'd1, 5'd5, 1'b1, 1'b0, 1'b1, 32'h111);
    @(posedge clk); #1;
    chk("halt pre imm", 64'(imm_ex), 64'(32'h111));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive_id(1'b1, 5'd5, 5'(k), 1'b1, 1'b1, 1'b0, 32'h1000 + 32'(k));
      halt = 1'b1;
      #1 chk($sformatf("halt%0d stall", k), 64'(stall), 64'(1'b0));
      @(posedge clk); #1;
      chk($sformatf("halt%0d imm", k), 64'(imm_ex), 64'(32'h111));
      chk($sformatf("halt%0d rs", k), 64'(rs_ex), 64'(5'd1));
      chk($sformatf("halt%0d mem_rd", k), 64'(mem_rd_ex), 64'(1'b1));
      chk($sformatf("halt%0d cnt", k), 64'(stall_count), 64'(16'h0));
    end
    // Release: every field of the current ID instruction is captured
    @(negedge clk);
    halt = 1'b0;
    valid_id = 1'b1; rs_id = 5'd4; rt_id = 5'd6; rd_id = 5'd3;
    uses_rs_id = 1'b1; uses_rt_id = 1'b1;
    rs_data = 32'hA5A5_A5A5; rt_data = 32'h5A5A_5A5A; imm = 32'h222;
    shamt = 5'd17; alu_op = 6'h2B; src_a = 2'd2; src_b = 1'b1;
    reg_wr_en = 1'b1; mem_rd = 1'b0; mem_wr = 1'b1; wb_src = 1'b1; reg_dst = 2'd3;
    #1 chk("rel stall", 64'(stall), 64'(1'b0));
    @(posedge clk); #1;
    chk("rel valid", 64'(valid_ex), 64'(1'b1));
    chk("rel rs", 64'(rs_ex), 64'(5'd4));
    chk("rel rt", 64'(rt_ex), 64'(5'd6));
    chk("rel rd", 64'(rd_ex), 64'(5'd3));
    chk("rel uses", 64'({uses_rs_ex, uses_rt_ex}), 64'(2'b11));
    chk("rel rs_data", 64'(rs_data_ex), 64'(32'hA5A5_A5A5));
    chk("rel rt_data", 64'(rt_data_ex), 64'(32'h5A5A_5A5A));
    chk("rel imm", 64'(imm_ex), 64'(32'h222));
    chk("rel shamt", 64'(shamt_ex), 64'(5'd17));
    chk("rel alu_op", 64'(alu_op_ex), 64'(6'h2B));
    chk("rel src", 64'({src_a_ex, src_b_ex}), 64'(3'b101));
    chk("rel ctrl", 64'({reg_wr_en_ex, mem_rd_ex, mem_wr_ex, wb_src_ex}), 64'(4'b1011));
    chk("rel reg_dst", 64'(reg_dst_ex), 64'(2'd3));

    // Saturation: 18 stalls, narrow counter pins at all-ones
    for (int k = 1; k <= 18; k++) begin
      hazard_pair(1'b0, $sformatf("sat%0d", k), 16'(k), (k >= 15) ? 4'hF : 4'(k));
    end
    // Clear with a hazard in the same cycle: clear wins
    hazard_pair(1'b1, "clr", 16'h0, 4'h0);

    // Async reset in the middle of a stall
    hazard_pair(1'b0, "prerst", 16'h1, 4'h1);
    @(negedge clk);
    drive_id(1'b1, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 32'h77);
    @(posedge clk); #1;
    @(negedge clk);
    drive_id(1'b1, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 32'h999);
    #1 chk("mid stall", 64'(stall), 64'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    chk("arst valid", 64'(valid_ex), 64'(1'b0));
    chk("arst rt", 64'(rt_ex), 64'(5'd0));
    chk("arst mem_rd", 64'(mem_rd_ex), 64'(1'b0));
    chk("arst stall", 64'(stall), 64'(1'b0));
    chk("arst cnt", 64'(stall_count), 64'(16'h0));
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post stall", 64'(stall), 64'(1'b0));
    @(posedge clk); #1;
    chk("post valid", 64'(valid_ex), 64'(1'b1));
    chk("post imm", 64'(imm_ex), 64'(32'h999));
    chk("post cnt", 64'(stall_count), 64'(16'h0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameters: DATA_W, 32, operand/immediate width; ALU_OP_W, 6, ALU opcode width; CNT_W, 16, stall-counter width.
REQ-002 SHALL have i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have i_valid_ID  input  1  ID holds a real instruction.
REQ-005 SHALL have i_rs_ID, i_rt_ID, i_rd_ID  input  5 each  register specifiers from decode.
REQ-006 SHALL have i_uses_rs_ID, i_uses_rt_ID  input  1 each  ID instruction reads rs / rt.
REQ-007 SHALL have i_rs_data, i_rt_data, i_imm  input  DATA_W each  register-file reads, sign-extended immediate.
REQ-008 SHALL have i_shamt  input  5; i_ALU_op  input  ALU_OP_W; i_flg_ALU_src_A  input  2; i_flg_ALU_src_B  input  1  EX controls.
REQ-009 SHALL have i_flg_reg_wr_en, i_flg_mem_rd, i_flg_mem_wr, i_flg_WB_src  input  1 each; i_flg_reg_dst  input  2  MEM/WB controls.
REQ-010 SHALL have i_flush  input  1  branch/jump taken; i_halt  input  1  debug freeze; i_cnt_clr  input  1  clear stall counter.
REQ-011 SHALL have o_* registered copies of every REQ-004..REQ-009 field with suffix _EX (o_valid_EX, o_rs_EX, o_rt_EX, ..., o_flg_reg_dst_EX), same widths.
REQ-012 SHALL have o_stall  output  1  combinational load-use stall request to PC and IF/ID.
REQ-013 SHALL have o_stall_count  output  CNT_W  number of load-use stall cycles.

Function
REQ-014 Load-use hazard SHALL be: o_valid_EX & o_flg_mem_rd_EX & o_rt_EX!=0 & i_valid_ID & ((i_uses_rs_ID & i_rs_ID==o_rt_EX) | (i_uses_rt_ID & i_rt_ID==o_rt_EX)).
REQ-015 o_stall SHALL equal hazard & ~i_flush & ~i_halt.
REQ-016 Per edge priority SHALL be halt > flush > stall > advance.
REQ-017 Halt: all _EX registers and counter SHALL hold; FSM enters HALT.
REQ-018 Flush or stall: register SHALL load a bubble: valid, reg_wr_en, mem_rd, mem_wr = 0; all other fields = 0.
REQ-019 Advance: register SHALL capture all ID inputs, latency exactly 1 cycle; i_valid_ID=0 SHALL load a bubble.
REQ-020 FSM states RUN, STALL, HALT; next state: i_halt->HALT, else o_stall->STALL, else RUN; HALT exit returns to RUN/STALL per same rule.
REQ-021 Because a bubble follows each stall, a stall SHALL last exactly one cycle per load-use pair; STALL->STALL only for back-to-back distinct hazards.
REQ-022 o_stall_count SHALL increment by 1 each cycle o_stall=1, saturate at all-ones, and clear when i_cnt_clr=1 (clear wins over increment).
REQ-023 Register 0 as load destination SHALL never cause a stall.

Reset
REQ-024 While i_rst_n=0: all _EX outputs 0 (bubble), o_stall_count 0, FSM RUN; o_stall therefore 0.
REQ-025 Reset assertion mid-stall or mid-halt SHALL abort immediately; first post-reset edge behaves as RUN.

Structure
REQ-026 Shared package SHALL hold DATA_W, ALU_OP_W, register-address width 5, FSM state encoding, and the bubble control constant.
REQ-027 Comparator logic of REQ-014 SHALL be sub-module load_use_detect (combinational); register/FSM/counter stay in id_ex_stage.

Verification
REQ-028 EX holds lw rt=5 valid; ID add uses_rs rs=5 -> o_stall=1; next cycle o_valid_EX=0, o_flg_mem_rd_EX=0; following cycle add lands in EX, o_stall_count=1.
REQ-029 Same as REQ-028 with i_flush=1 -> o_stall=0, bubble loaded, counter unchanged.
REQ-030 EX lw rt=0, ID rs=0 -> o_stall=0, ID instruction advances in 1 cycle.
REQ-031 i_halt=1 for 3 cycles with ID fields changing -> _EX outputs and counter frozen, o_stall=0; release -> next edge captures current ID.
REQ-032 Counter preset near all-ones via repeated hazards -> stays 0xFFFF; i_cnt_clr with hazard same cycle -> 0.
REQ-033 i_rst_n pulsed low asynchronously during STALL -> outputs 0 before next edge, o_stall_count=0.
